// File: rtl/exe_muldiv_unit.sv
// ---------------------------------------------------------------------------
// exe_muldiv_unit
// Multi-cycle multiply/divide engine for the execute stage. It computes
// MULT, MULTU, DIV and DIVU into HI/LO result registers, holds the pipeline
// with stall_req while an operation is in flight, and can be cancelled by
// flush.
//
// Parameters:
//   WIDTH       operand width, HI/LO are WIDTH bits each (>= 4)
//   MUL_STAGES  cycles from accepted start to done for multiplies (1..4)
//
// Ports:
//   clk          clock
//   rstn         asynchronous active-low reset
//   start        operation request, accepted only when idle and not flushed
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1         multiplicand / dividend (rs)
//   src2         multiplier / divisor (rt)
//   flush        cancel any in-flight operation
//   stall_req    pipeline hold request (combinational)
//   busy         engine not idle (registered)
//   done         one-cycle pulse, hi_out/lo_out valid
//   div_by_zero  pulses with done when a divide had a zero divisor
//   hi_out       product high half / remainder
//   lo_out       product low half / quotient
// ---------------------------------------------------------------------------
module exe_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW     = $clog2(WIDTH + 1);
    // The multiply pipe holds MUL_STAGES-1 stages; keep at least one entry
    // so the array stays legal when the multiply result is registered
    // straight into HI/LO.
    localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int LAST   = PIPE_N - 1;

    localparam logic [CW-1:0] MUL_LAST = CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mulPipe [PIPE_N];
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic               r_negQ;
    logic               r_negR;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_signed;
    logic               w_divZero;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [2*WIDTH-1:0] w_prodMag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_diff;
    logic               w_qBit;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quoNext;
    logic [WIDTH-1:0]   w_quoFinal;
    logic [WIDTH-1:0]   w_remFinal;
    logic               w_mulLast;
    logic               w_divLast;
    logic               w_load;
    logic [WIDTH-1:0]   w_hiNext;
    logic [WIDTH-1:0]   w_loNext;

    // Operand conditioning: the signed variants work on magnitudes and
    // re-apply the sign at the end, so one unsigned datapath serves both.
    assign w_accept  = start & (r_state == S_IDLE) & ~flush;
    assign w_signed  = ~op[0];
    assign w_divZero = (src2 == '0);
    assign w_neg1    = w_signed & src1[WIDTH-1];
    assign w_neg2    = w_signed & src2[WIDTH-1];
    assign w_abs1    = w_neg1 ? -src1 : src1;
    assign w_abs2    = w_neg2 ? -src2 : src2;
    assign w_prodMag = {{WIDTH{1'b0}}, w_abs1} * {{WIDTH{1'b0}}, w_abs2};
    assign w_prod    = (w_neg1 ^ w_neg2) ? -w_prodMag : w_prodMag;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and keep the subtraction only if it did not go
    // negative. The remainder always stays below the divisor, so the
    // shifted value fits in WIDTH+1 bits and the top bit of the difference
    // is a reliable borrow.
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_remShift - {1'b0, r_div};
    assign w_qBit     = ~w_diff[WIDTH];
    assign w_remNext  = w_qBit ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
    assign w_quoNext  = {r_quo[WIDTH-2:0], w_qBit};
    assign w_quoFinal = r_negQ ? -w_quoNext : w_quoNext;
    assign w_remFinal = r_negR ? -w_remNext : w_remNext;

    assign w_mulLast = (r_cnt == MUL_LAST);
    assign w_divLast = (r_cnt == DIV_LAST);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_busy  <= (w_nextState != S_IDLE);
        end
    end

    // Next-state logic. Flush overrides everything, which also blocks a
    // start arriving in the same cycle. A single-stage multiply and a
    // divide by zero have their result ready at acceptance and go straight
    // to DONE.
    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[1]) begin
                            w_nextState = (MUL_STAGES == 1) ? S_DONE : S_MUL;
                        end else begin
                            w_nextState = w_divZero ? S_DONE : S_DIV;
                        end
                    end
                end
                S_MUL:   if (w_mulLast) w_nextState = S_DONE;
                S_DIV:   if (w_divLast) w_nextState = S_DONE;
                S_DONE:  w_nextState = S_IDLE;
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Outputs. stall_req drops in the DONE cycle so the pipeline advances
    // together with the result.
    always_comb begin
        stall_req   = (start & (r_state == S_IDLE) & ~flush)
                    | (r_state == S_MUL) | (r_state == S_DIV);
        done        = (r_state == S_DONE);
        div_by_zero = (r_state == S_DONE) & r_dbz;
        busy        = r_busy;
        hi_out      = r_hi;
        lo_out      = r_lo;
    end

    // Result selection. HI/LO are loaded only on the transition into DONE,
    // so a flush, which never reaches DONE, leaves them untouched.
    always_comb begin
        w_load   = 1'b0;
        w_hiNext = '0;
        w_loNext = '0;
        if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start && op[1] && w_divZero) begin
                        w_load   = 1'b1;
                        w_hiNext = src1;
                        w_loNext = '1;
                    end else if (start && !op[1] && (MUL_STAGES == 1)) begin
                        w_load                = 1'b1;
                        {w_hiNext, w_loNext}  = w_prod;
                    end
                end
                S_MUL: begin
                    if (w_mulLast) begin
                        w_load               = 1'b1;
                        {w_hiNext, w_loNext} = r_mulPipe[LAST];
                    end
                end
                S_DIV: begin
                    if (w_divLast) begin
                        w_load   = 1'b1;
                        w_hiNext = w_remFinal;
                        w_loNext = w_quoFinal;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers. Acceptance snapshots the conditioned operands and
    // the first multiply stage; after that the multiply pipe just shifts,
    // and the divider iterates while in DIV. The shared counter saturates
    // instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            for (int k = 0; k < PIPE_N; k++) r_mulPipe[k] <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_negQ <= 1'b0;
            r_negR <= 1'b0;
            r_dbz  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            for (int k = 1; k < PIPE_N; k++) r_mulPipe[k] <= r_mulPipe[k-1];
            if (w_accept) begin
                r_cnt        <= '0;
                r_mulPipe[0] <= w_prod;
                r_quo        <= w_abs1;
                r_rem        <= '0;
                r_div        <= w_abs2;
                r_negQ       <= w_neg1 ^ w_neg2;
                r_negR       <= w_neg1;
                r_dbz        <= op[1] & w_divZero;
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
            end
            if (r_state == S_DIV) begin
                r_rem <= w_remNext;
                r_quo <= w_quoNext;
            end
            if (w_load) begin
                r_hi <= w_hiNext;
                r_lo <= w_loNext;
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_exe_muldiv_unit
// Scoreboard bench for exe_muldiv_unit (WIDTH=32, MUL_STAGES=2). Stimulus
// pushes the expected HI/LO/div_by_zero and done cycle into a queue; a
// monitor pops and compares whenever done is seen. Expected results come
// from plain 64-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_exe_muldiv_unit;

    localparam int WIDTH      = 32;
    localparam int MUL_STAGES = 2;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        expQ [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;

    exe_muldiv_unit #(
        .WIDTH      (WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .flush       (flush),
        .stall_req   (stall_req),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    // Free-running clock and a cycle counter used to time done pulses.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: results from the arithmetic definition of each op.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input int c);
        exp_t               e;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] r64;
        logic signed [63:0] q64;
        sa    = {{32{a[31]}}, a};
        sb    = {{32{b[31]}}, b};
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        e.cyc = c;
        case (o)
            2'b00: begin
                r64  = sa * sb;
                e.hi = r64[63:32];
                e.lo = r64[31:0];
                e.cyc = c + MUL_STAGES;
            end
            2'b01: begin
                r64  = {32'b0, a} * {32'b0, b};
                e.hi = r64[63:32];
                e.lo = r64[31:0];
                e.cyc = c + MUL_STAGES;
            end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.cyc = c + 1;
                end else begin
                    if (o == 2'b10) begin
                        q64 = sa / sb;
                        r64 = sa % sb;
                    end else begin
                        q64 = {32'b0, a} / {32'b0, b};
                        r64 = {32'b0, a} % {32'b0, b};
                    end
                    e.lo  = q64[31:0];
                    e.hi  = r64[31:0];
                    e.cyc = c + WIDTH + 1;
                end
            end
        endcase
        return e;
    endfunction

    // Issue one operation once the engine is idle; optionally record what
    // the monitor should see for it. Entered and left just after a rising
    // edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input bit expectDone);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) checkOutput("idle_timeout", 64'(busy), 64'(0));
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        #1;
        checkOutput("stall_on_start", 64'(stall_req), 64'(1));
        if (expectDone) expQ.push_back(model(o, a, b, cyc));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (rstn && done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: actual=done required=no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("hi_out", 64'(hi_out), 64'(e.hi));
                checkOutput("lo_out", 64'(lo_out), 64'(e.lo));
                checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("stall_in_done", 64'(stall_req), 64'(0));
                lastHi = e.hi;
                lastLo = e.lo;
            end
        end
    end

    // Main sequence: reset, directed cases, flush/reset corner cases, then
    // a randomized run.
    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src1  = '0;
        src2  = '0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_hi", 64'(hi_out), 64'(0));
        checkOutput("rst_lo", 64'(lo_out), 64'(0));
        checkOutput("rst_stall", 64'(stall_req), 64'(0));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed multiply and divide");
        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
        checkOutput("stall_T1", 64'(stall_req), 64'(1));
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b1);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(2'b11, 32'd5, 32'd0, 1'b1);
        applyStimulus(2'b11, 32'd50, 32'd6, 1'b1);
        applyStimulus(2'b10, 32'd0, 32'd0, 1'b1);
        applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);

        $display("[TB] flush during divide");
        applyStimulus(2'b10, 32'hFFFF_FF9C, 32'd3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b01;
        src1  = 32'd9;
        src2  = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_in_div", 64'(busy), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'(0));
        checkOutput("flush_stall", 64'(stall_req), 64'(0));
        checkOutput("flush_hi_hold", 64'(hi_out), 64'(lastHi));
        checkOutput("flush_lo_hold", 64'(lo_out), 64'(lastLo));
        repeat (40) @(posedge clk);
        #1;

        $display("[TB] start with flush in idle");
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        src1  = 32'd7;
        src2  = 32'd7;
        #1;
        checkOutput("startflush_stall", 64'(stall_req), 64'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("startflush_busy", 64'(busy), 64'(0));
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] asynchronous reset mid-divide");
        applyStimulus(2'b11, 32'd1000, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst_hi", 64'(hi_out), 64'(0));
        checkOutput("arst_lo", 64'(lo_out), 64'(0));
        checkOutput("arst_busy", 64'(busy), 64'(0));
        checkOutput("arst_done", 64'(done), 64'(0));
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        lastHi = '0;
        lastLo = '0;
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(2'b00, 32'd3, 32'd4, 1'b1);

        $display("[TB] randomized operations");
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(ro, ra, rb, 1'b1);
        end

        // Drain the scoreboard with a bound.
        for (int n = 0; n < 200 && expQ.size() != 0; n++) @(posedge clk);
        #1;
        while (expQ.size() != 0) begin
            void'(expQ.pop_front());
            checks++;
            errors++;
            $display("[TB] FAIL missing_done: actual=no done required=done");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
